// File: rtl/hanoi_move_sequencer.sv
// Tower-of-Hanoi move sequencer: drives the fr/to move port of the peg
// register file, either solving the whole tower from peg 0 to peg 2 or
// forwarding single host moves that pass a legality check against a
// local shadow copy of ring positions.
//
// state | meaning
// IDLE  | host moves accepted; a start launches a solve when all rings are home
// RUN   | automatic solve in progress; one move presented per transfer
// DONE  | solve finished; done is high for this single cycle
module hanoi_move_sequencer #(
   parameter int S = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     host_valid,
   input  logic [1:0]               host_fr,
   input  logic [1:0]               host_to,
   output logic                     host_ready,
   output logic                     move_valid,
   input  logic                     move_ready,
   output logic [1:0]               move_fr,
   output logic [1:0]               move_to,
   output logic [$clog2(S+1)-1:0]   move_disk,
   output logic                     busy,
   output logic                     done,
   output logic                     cmd_err,
   output logic [S-1:0]             move_cnt
);

   localparam int DW = $clog2(S+1);
   localparam logic [S-1:0] K_ONE  = S'(1);
   localparam logic [S-1:0] K_LAST = {S{1'b1}};
   localparam logic [S:0]   ONE_W   = (S+1)'(1);
   localparam logic [S:0]   THREE_W = (S+1)'(3);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [S-1:0]    k;
   logic [1:0]      pos [1:S];

   logic [DW-1:0]   top_of [4];
   logic [DW-1:0]   top_fr;
   logic [DW-1:0]   top_to;
   logic            all_home;
   logic            host_legal;
   logic            xfer;
   logic            abort_run;

   logic [S-1:0]    k_next;
   logic [S:0]      kk;
   logic [S:0]      gen_a;
   logic [S:0]      gen_b;
   logic [1:0]      gen_fr;
   logic [1:0]      gen_to;
   logic [DW-1:0]   gen_disk;
   logic            gen_found;

   function automatic logic [1:0] swap12(input logic [1:0] p);
      if (p == 2'd1)      swap12 = 2'd2;
      else if (p == 2'd2) swap12 = 2'd1;
      else                swap12 = p;
   endfunction

   assign xfer       = move_valid && move_ready;
   assign abort_run  = (state == RUN) && abort;
   assign host_ready = !rst && (state == IDLE) && !move_valid && !start;

   // Smallest ring on each peg (0 = empty); index 3 is never a valid peg and stays 0
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         top_of[p] = '0;
         for (int d = S; d >= 1; d--) begin
            if (pos[d] == 2'(p)) top_of[p] = DW'(d);
         end
      end
   end

   // Host move legality and the all-rings-on-peg-0 precondition for a solve
   always_comb begin
      all_home = 1'b1;
      for (int d = 1; d <= S; d++) begin
         if (pos[d] != 2'd0) all_home = 1'b0;
      end
      top_fr     = top_of[host_fr];
      top_to     = top_of[host_to];
      host_legal = (host_fr != 2'd3) && (host_to != 2'd3) && (host_fr != host_to) &&
                   (top_fr != '0) && ((top_to == '0) || (top_to > top_fr));
   end

   // Closed-form generator for the next solve move; odd/even S differ only by a 1<->2 peg swap
   always_comb begin
      k_next    = (state == RUN) ? k + K_ONE : K_ONE;
      kk        = {1'b0, k_next};
      gen_a     = kk & (kk - ONE_W);
      gen_b     = (kk | (kk - ONE_W)) + ONE_W;
      gen_fr    = 2'(gen_a % THREE_W);
      gen_to    = 2'(gen_b % THREE_W);
      if ((S % 2) == 0) begin
         gen_fr = swap12(gen_fr);
         gen_to = swap12(gen_to);
      end
      gen_disk  = DW'(1);
      gen_found = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (!gen_found) begin
            if (k_next[i]) gen_found = 1'b1;
            else           gen_disk  = gen_disk + DW'(1);
         end
      end
   end

   // Control FSM, registered move port and shadow ring positions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         move_cnt   <= '0;
         move_valid <= 1'b0;
         move_fr    <= 2'd0;
         move_to    <= 2'd0;
         move_disk  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
         for (int d = 1; d <= S; d++) pos[d] <= 2'd0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         // an aborted move is never handed over, so the shadow must not follow it
         if (xfer && !abort_run) pos[move_disk] <= move_to;
         unique case (state)
            IDLE: begin
               if (xfer) move_valid <= 1'b0;
               if (start) begin
                  if (!move_valid && all_home) begin
                     state      <= RUN;
                     busy       <= 1'b1;
                     k          <= K_ONE;
                     move_cnt   <= '0;
                     move_valid <= 1'b1;
                     move_fr    <= gen_fr;
                     move_to    <= gen_to;
                     move_disk  <= gen_disk;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end else if (host_valid && host_ready) begin
                  if (host_legal) begin
                     move_valid <= 1'b1;
                     move_fr    <= host_fr;
                     move_to    <= host_to;
                     move_disk  <= top_fr;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  move_valid <= 1'b0;
               end else if (xfer) begin
                  move_cnt <= move_cnt + K_ONE;
                  if (k == K_LAST) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     move_valid <= 1'b0;
                  end else begin
                     k         <= k_next;
                     move_fr   <= gen_fr;
                     move_to   <= gen_to;
                     move_disk <= gen_disk;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Directed bench for hanoi_move_sequencer: an S=3 instance for the main
// scenarios plus an S=2 instance for the even-ring solve. Expected moves are
// queued when stimulus is driven and popped as transfers are observed.
module tb_hanoi_move_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, host_valid, move_ready;
   logic [1:0] host_fr, host_to;
   logic       host_ready, move_valid, busy, done, cmd_err;
   logic [1:0] move_fr, move_to, move_disk;
   logic [2:0] move_cnt;

   logic       start2, abort2, host_valid2, move_ready2;
   logic [1:0] host_fr2, host_to2;
   logic       host_ready2, move_valid2, busy2, done2, cmd_err2;
   logic [1:0] move_fr2, move_to2, move_disk2;
   logic [1:0] move_cnt2;

   int checks = 0;
   int errors = 0;

   logic [5:0] q3[$];
   logic [5:0] q2[$];
   logic [5:0] sol3 [7];
   logic [5:0] sol2 [3];

   hanoi_move_sequencer #(.S(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .host_valid(host_valid), .host_fr(host_fr), .host_to(host_to), .host_ready(host_ready),
      .move_valid(move_valid), .move_ready(move_ready), .move_fr(move_fr), .move_to(move_to),
      .move_disk(move_disk), .busy(busy), .done(done), .cmd_err(cmd_err), .move_cnt(move_cnt)
   );

   hanoi_move_sequencer #(.S(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .host_valid(host_valid2), .host_fr(host_fr2), .host_to(host_to2), .host_ready(host_ready2),
      .move_valid(move_valid2), .move_ready(move_ready2), .move_fr(move_fr2), .move_to(move_to2),
      .move_disk(move_disk2), .busy(busy2), .done(done2), .cmd_err(cmd_err2), .move_cnt(move_cnt2)
   );

   function automatic logic [5:0] mk(input int fr, input int to, input int disk);
      mk = {2'(fr), 2'(to), 2'(disk)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // S=3 transfer monitor: scoreboard pop plus hold-while-stalled check
   logic       pend3 = 1'b0;
   logic [5:0] held3 = '0;
   always @(negedge clk) begin
      if (rst) begin
         pend3 = 1'b0;
      end else begin
         if (pend3) begin
            check("hold_valid", move_valid, 1);
            check("hold_move", {move_fr, move_to, move_disk}, held3);
         end
         if (move_valid && move_ready && !abort) begin
            check("move3_expected", q3.size() != 0, 1);
            if (q3.size() != 0) check("move3", {move_fr, move_to, move_disk}, q3.pop_front());
         end
         pend3 = move_valid && !move_ready && !abort;
         held3 = {move_fr, move_to, move_disk};
      end
   end

   // S=2 transfer monitor
   always @(negedge clk) begin
      if (!rst && move_valid2 && move_ready2) begin
         check("move2_expected", q2.size() != 0, 1);
         if (q2.size() != 0) check("move2", {move_fr2, move_to2, move_disk2}, q2.pop_front());
      end
   end

   task automatic run_solve3(input bit toggle);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 7; i++) q3.push_back(sol3[i]);
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         sample();
         if (done) begin
            seen = 1'b1;
         end else begin
            check("busy_run", busy, 1);
            tick();
            if (toggle) move_ready = 1'($urandom_range(0, 1));
         end
      end
      check("solve_done", seen, 1);
      check("move_cnt_final", move_cnt, 7);
      check("busy_after", busy, 0);
      check("queue3_drained", q3.size(), 0);
      tick(); sample();
      check("done_one_cycle", done, 0);
      check("move_cnt_hold", move_cnt, 7);
      move_ready = 1'b1;
   endtask

   task automatic host_req(input logic [1:0] fr, input logic [1:0] to, input bit ok, input logic [1:0] disk);
      tick();
      host_valid = 1'b1; host_fr = fr; host_to = to;
      if (ok) q3.push_back({fr, to, disk});
      tick();
      host_valid = 1'b0;
      sample();
      check("host_cmd_err", cmd_err, !ok);
      check("host_move_valid", move_valid, ok);
      if (ok) begin
         tick(); sample();
         check("host_move_gone", move_valid, 0);
      end
   endtask

   task automatic start_rejected();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      sample();
      check("start_cmd_err", cmd_err, 1);
      check("start_stays_idle", busy, 0);
      check("start_no_move", move_valid, 0);
      tick(); sample();
      check("cmd_err_pulse", cmd_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen2;
      sol3 = '{mk(0,2,1), mk(0,1,2), mk(2,1,1), mk(0,2,3), mk(1,0,1), mk(1,2,2), mk(0,2,1)};
      sol2 = '{mk(0,1,1), mk(0,2,2), mk(1,2,1)};
      rst = 1'b1; start = 1'b0; abort = 1'b0; host_valid = 1'b0;
      host_fr = 2'd0; host_to = 2'd0; move_ready = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; host_valid2 = 1'b0;
      host_fr2 = 2'd0; host_to2 = 2'd0; move_ready2 = 1'b1;

      repeat (2) tick();
      sample();
      check("rst_move_valid", move_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_err", cmd_err, 0);
      check("rst_move_cnt", move_cnt, 0);
      check("rst_host_ready", host_ready, 0);
      check("rst_move", {move_fr, move_to, move_disk}, 0);
      check("rst_move_valid2", move_valid2, 0);
      tick(); rst = 1'b0;
      sample();
      check("idle_host_ready", host_ready, 1);

      // even ring count: tower must still end on peg 2
      for (int i = 0; i < 3; i++) q2.push_back(sol2[i]);
      tick(); start2 = 1'b1;
      tick(); start2 = 1'b0;
      seen2 = 1'b0;
      for (int c = 0; c < 20 && !seen2; c++) begin
         sample();
         if (done2) seen2 = 1'b1;
      end
      check("solve2_done", seen2, 1);
      check("move_cnt2", move_cnt2, 3);
      check("queue2_drained", q2.size(), 0);

      // full solve, ready held high
      move_ready = 1'b1;
      run_solve3(1'b0);

      // rings now on peg 2: start rejected, host (2,0) moves ring 1
      start_rejected();
      tick();
      move_ready = 1'b0; host_valid = 1'b1; host_fr = 2'd2; host_to = 2'd0;
      q3.push_back(mk(2,0,1));
      sample();
      check("host_ready_req", host_ready, 1);
      tick(); host_valid = 1'b0;
      sample();
      check("host_pending", move_valid, 1);
      check("host_pending_disk", move_disk, 1);
      check("host_ready_busy", host_ready, 0);
      tick(); sample();
      tick(); move_ready = 1'b1;
      sample();
      tick(); sample();
      check("host_done", move_valid, 0);
      check("queue_host", q3.size(), 0);

      // host legality from reset
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      host_req(2'd1, 2'd0, 1'b0, 2'd0);
      host_req(2'd0, 2'd1, 1'b1, 2'd1);
      host_req(2'd0, 2'd1, 1'b0, 2'd0);
      host_req(2'd0, 2'd0, 1'b0, 2'd0);
      host_req(2'd3, 2'd1, 1'b0, 2'd0);
      start_rejected();
      host_req(2'd1, 2'd0, 1'b1, 2'd1);

      // abort while move 4 is presented with ready high
      for (int i = 0; i < 3; i++) q3.push_back(sol3[i]);
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      abort = 1'b1;
      sample();
      check("abort_move4", {move_fr, move_to, move_disk}, mk(0,2,3));
      check("abort_cnt_before", move_cnt, 3);
      tick(); abort = 1'b0;
      sample();
      check("abort_valid", move_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_cnt_after", move_cnt, 3);
      check("abort_host_ready", host_ready, 1);
      check("queue_abort", q3.size(), 0);
      start_rejected();
      host_req(2'd0, 2'd2, 1'b1, 2'd3);

      // reset in the middle of a solve
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      q3.push_back(sol3[0]);
      q3.push_back(sol3[1]);
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      check("midrst_valid", move_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt", move_cnt, 0);
      check("queue_midrst", q3.size(), 0);
      tick(); rst = 1'b0;

      // full solve with move_ready stalls
      run_solve3(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hanoi_move_sequencer.md
Name: hanoi_move_sequencer

Overview:
Controller that drives the fr/to move port of the Tower-of-Hanoi peg register file. It either generates the complete optimal solution autonomously, moving all S rings from peg 0 to peg 2, or forwards single host-requested moves after a legality check. It keeps its own shadow model of ring positions, so the downstream register file only ever sees legal moves: source non-empty, no larger ring placed on a smaller one.

Parameters:
S, 3, number of rings; ring 1 is the smallest, ring S the largest; S >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  request an automatic solve; single-cycle qualifier
abort  in  1  stop an automatic solve; synchronous
host_valid  in  1  host move request valid
host_fr  in  2  host source peg, 0..2
host_to  in  2  host destination peg, 0..2
host_ready  out  1  host request accepted this cycle
move_valid  out  1  move presented to the datapath
move_ready  in  1  datapath consumes the move
move_fr  out  2  source peg
move_to  out  2  destination peg
move_disk  out  $clog2(S+1)  ring being moved
busy  out  1  high in RUN
done  out  1  one-cycle pulse when an automatic solve completes
cmd_err  out  1  one-cycle pulse when a request is rejected
move_cnt  out  S  moves issued in the current automatic solve

Behaviour:
- Reset, async, asserted: state IDLE; all outputs 0; move counter k = 0; shadow model pos[d] = 0 for every ring d.
- Shadow model: pos[d] is 2 bits per ring. top(p) is the smallest d with pos[d] == p, or 0 if peg p is empty. pos[move_disk] <= move_to on every transfer, i.e. each cycle with move_valid && move_ready.
- Legality of (f, t): f <= 2, t <= 2, f != t, top(f) != 0, and either top(t) == 0 or top(t) > top(f).
- States: IDLE, RUN, DONE.
- IDLE, host path:
  - host_ready = (state == IDLE) && !move_valid && !start.
  - Legal accepted request: register move_fr/move_to/move_disk = top(f); move_valid rises next cycle and holds until transfer.
  - Illegal accepted request: dropped; cmd_err pulses next cycle.
- IDLE, start:
  - Accepted only when !move_valid and pos[d] == 0 for all d.
  - If rejected: cmd_err pulses next cycle, stay in IDLE.
  - If accepted: next cycle RUN, k = 1, move_valid = 1, move registers hold move(1).
- Move generator for move k (1 .. 2^S-1):
  - move_disk = 1 + trailing zeros of k.
  - fr = (k & (k-1)) mod 3.
  - to = ((k | (k-1)) + 1) mod 3, computed in S+1 bits.
  - For even S, swap peg codes 1 and 2 in fr and to, so the tower always ends on peg 2.
- RUN:
  - move_valid stays high; move_* outputs stay stable until transfer.
  - On transfer with k < 2^S-1: k <= k+1 and move(k+1) is loaded the same edge, so there is no bubble.
  - On transfer with k == 2^S-1: move_valid <= 0; next state DONE.
  - move_cnt = number of completed transfers in the current solve.
  - busy = 1 throughout RUN.
- DONE: done = 1 for exactly one cycle, then IDLE. move_cnt holds 2^S-1 until the next accepted start.
- abort in RUN: next cycle IDLE, move_valid = 0. The pending move is discarded even if move_ready is high in the same cycle, so no pos update occurs. abort outside RUN has no effect.
- start while in RUN or DONE: ignored, no cmd_err.
- Reset mid-solve: immediate return to the reset values. The datapath is reset together with this block, so the models stay consistent.
- move_valid must never drop without a transfer, except on abort or reset.

Test Plan:
- S=3, reset, start, move_ready held 1 -> 7 consecutive transfers (fr,to,disk): (0,2,1) (0,1,2) (2,1,1) (0,2,3) (1,0,1) (1,2,2) (0,2,1); done pulses 1 cycle after the last transfer; move_cnt = 7; pos all 2.
- S=3, move_ready toggled 1-0-0-1 pseudo-randomly during a solve -> move_* stable while move_valid && !move_ready; same 7-move sequence; busy = 1 from the cycle after start until DONE.
- S=2 solve -> (0,1,1) (0,2,2) (1,2,1); done after 3 transfers.
- After a completed solve, start -> rejected, cmd_err = 1 one cycle later, state stays IDLE; host move (2,0) -> accepted, move_disk = 1.
- From reset: host (1,0) -> cmd_err (empty source); host (0,1) accepted, then host (0,1) -> cmd_err (ring 2 onto ring 1); host (0,0) -> cmd_err.
- Abort at k = 4 with move_ready = 1 in the same cycle -> no transfer counted, pos unchanged, IDLE next cycle; subsequent start -> cmd_err (not all rings on peg 0).
